// File: rtl/bcd_serial_addsub_if.sv
// Operand/result handshake bundle for bcd_serial_addsub: request side (operands, mode)
// and response side (packed BCD result plus carry/borrow and digit-error flags).
interface bcd_serial_addsub_if #(
  parameter int NDIGITS = 4
);
  localparam int W = 4 * NDIGITS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         of;
  logic         err;

  modport master (
    output in_valid, num1, num2, sub, out_ready,
    input  in_ready, out_valid, out, of, err
  );

  modport slave (
    input  in_valid, num1, num2, sub, out_ready,
    output in_ready, out_valid, out, of, err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Serial N-digit packed-BCD add/subtract, one digit per clock LSD first; result valid NDIGITS clocks
// after accept and held in DONE until out_ready. Optional digit check under BCD_DIGIT_CHECK_EN.
module bcd_serial_addsub #(
  parameter  int NDIGITS = 4,
  localparam int W       = 4 * NDIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_serial_addsub_if.slave    bus
);
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_out;
  logic           r_sub;
  logic           r_carry;
  logic           r_of;
  logic [CW-1:0]  r_cnt;

  logic           w_accept;
  logic           w_last;
  logic [3:0]     w_b_adj;
  logic [4:0]     w_sum;
  logic           w_carry_nxt;
  logic [3:0]     w_digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)        w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == CW'(NDIGITS - 1));

  // Subtraction adds the nine's complement with carry-in 1, giving ten's complement.
  assign w_b_adj     = r_sub ? (4'd9 - r_b[3:0]) : r_b[3:0];
  assign w_sum       = {1'b0, r_a[3:0]} + {1'b0, w_b_adj} + {4'd0, r_carry};
  assign w_carry_nxt = (w_sum > 5'd9);
  assign w_digit     = w_carry_nxt ? 4'(w_sum - 5'd10) : w_sum[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_of    <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.num1;
      r_b     <= bus.num2;
      r_sub   <= bus.sub;
      r_carry <= bus.sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a                <= r_a >> 4;
      r_b                <= r_b >> 4;
      r_carry            <= w_carry_nxt;
      r_out[4*r_cnt +: 4] <= w_digit;
      r_cnt              <= r_cnt + 1'b1;
      if (w_last) r_of   <= r_sub ? ~w_carry_nxt : w_carry_nxt;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic r_err;

  function automatic logic any_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_err <= 1'b0;
    else if (w_accept) r_err <= any_bad_digit(bus.num1) | any_bad_digit(bus.num2);
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out       = r_out;
  assign bus.of        = r_of;
endmodule
